// File: rtl/axis_master_fifo.sv
// AXI4-Stream master: FIFO of {TLAST,TKEEP,TDATA} feeding a registered output stage.
// Define AXIS_MASTER_FIFO_PACKET_MODE_EN for store-and-forward (with full-FIFO fallback).
module axis_master_fifo #(
  parameter int unsigned FIFO_DEPTH           = 4,
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                  M_AXIS_ACLK,
  input  logic                                  M_AXIS_ARESET,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]       TDATA_in,
  input  logic [C_M_AXIS_TDATA_WIDTH/8-1:0]     TKEEP_in,
  input  logic                                  TLAST_in,
  input  logic                                  TVALID_in,
  output logic                                  TREADY_out,
  input  logic                                  M_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]     M_AXIS_TKEEP,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]     M_AXIS_TSTRB,
  output logic                                  M_AXIS_TLAST,
  output logic                                  M_AXIS_TVALID,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_level,
  output logic                                  overflow
);

  localparam int unsigned DW = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned KW = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DW + KW + 1;

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_rdy_en;
  logic          r_overflow;
  logic          r_tvalid;
  logic          r_tlast;
  logic [DW-1:0] r_tdata;
  logic [KW-1:0] r_tkeep;

  logic          w_empty;
  logic          w_full;
  logic          w_wr;
  logic          w_load;
  logic [EW-1:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // r_rdy_en keeps TREADY_out low during reset and until the first edge after release
  assign TREADY_out = r_rdy_en && !w_full;
  assign w_wr       = TVALID_in && TREADY_out;

`ifdef AXIS_MASTER_FIFO_PACKET_MODE_EN
  logic [PW-1:0] r_pkt_cnt;

  // Hold words until a whole packet is stored, unless the FIFO is full (long packets)
  assign w_load = !w_empty && (!r_tvalid || M_AXIS_TREADY) &&
                  ((r_pkt_cnt != '0) || w_full);

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      r_pkt_cnt <= '0;
    end else begin
      case ({w_wr && TLAST_in, w_load && w_head[EW-1]})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + PW'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - PW'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end
`else
  assign w_load = !w_empty && (!r_tvalid || M_AXIS_TREADY);
`endif

  // Storage array carries no reset; pointers define what is valid
  always_ff @(posedge M_AXIS_ACLK) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {TLAST_in, TKEEP_in, TDATA_in};
    end
  end

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rdy_en   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (TVALID_in && !TREADY_out) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Output stage: load from head when free or draining, else clear/hold
  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tlast  <= w_head[EW-1];
      r_tkeep  <= w_head[DW +: KW];
      r_tdata  <= w_head[DW-1:0];
    end else if (M_AXIS_TREADY) begin
      r_tvalid <= 1'b0;
    end
  end

  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TLAST  = r_tlast;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TKEEP  = r_tkeep;
  assign M_AXIS_TSTRB  = r_tkeep;
  assign fifo_level    = r_wr_ptr - r_rd_ptr;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_axis_master_fifo.sv
// Randomized bench for axis_master_fifo against a queue-based reference model.
module tb_axis_master_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned KW    = 4;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tdata_in = '0;
  logic [KW-1:0] tkeep_in = '0;
  logic          tlast_in = 1'b0;
  logic          tvalid_in = 1'b0;
  logic          tready_out;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [KW-1:0] m_tstrb;
  logic          m_tlast;
  logic          m_tvalid;
  logic [2:0]    level;
  logic          ovf;

  axis_master_fifo #(.FIFO_DEPTH(DEPTH), .C_M_AXIS_TDATA_WIDTH(DW)) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst),
    .TDATA_in(tdata_in), .TKEEP_in(tkeep_in), .TLAST_in(tlast_in),
    .TVALID_in(tvalid_in), .TREADY_out(tready_out),
    .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(m_tdata), .M_AXIS_TKEEP(m_tkeep),
    .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TLAST(m_tlast), .M_AXIS_TVALID(m_tvalid),
    .fifo_level(level), .overflow(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: stored words as a queue plus the visible output beat
  ent_t m_q[$];
  ent_t m_out;
  logic m_vld;
  logic m_ovf;
  logic m_rdy_en;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return m_rdy_en && (m_q.size() < DEPTH);
  endfunction

  function automatic int lasts_stored();
    int n = 0;
    foreach (m_q[i]) if (m_q[i].last) n++;
    return n;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_tready_out"}, 64'(tready_out), 64'(model_ready()));
    chk({tag, "_tvalid"}, 64'(m_tvalid), 64'(m_vld));
    chk({tag, "_tdata"}, 64'(m_tdata), 64'(m_out.data));
    chk({tag, "_tkeep"}, 64'(m_tkeep), 64'(m_out.keep));
    chk({tag, "_tstrb"}, 64'(m_tstrb), 64'(m_out.keep));
    chk({tag, "_tlast"}, 64'(m_tlast), 64'(m_out.last));
    chk({tag, "_level"}, 64'(level), 64'(m_q.size()));
    chk({tag, "_overflow"}, 64'(ovf), 64'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic cycle(input string tag, input logic tv, input ent_t e, input logic trdy);
    logic full, rdy, load;
    tvalid_in = tv;
    tdata_in  = e.data;
    tkeep_in  = e.keep;
    tlast_in  = e.last;
    m_tready  = trdy;
    full = (m_q.size() == DEPTH);
    rdy  = model_ready();
    load = (m_q.size() != 0) && (!m_vld || trdy);
`ifdef AXIS_MASTER_FIFO_PACKET_MODE_EN
    load = load && ((lasts_stored() != 0) || full);
`endif
    if (load) begin
      m_out = m_q.pop_front();
      m_vld = 1'b1;
    end else if (trdy) begin
      m_vld = 1'b0;
    end
    if (tv && rdy) m_q.push_back(e);
    else if (tv)   m_ovf = 1'b1;
    m_rdy_en = 1'b1;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n, input logic trdy);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, '0, trdy);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    tvalid_in = 1'b0;
    #1;
    m_q.delete();
    m_out    = '0;
    m_vld    = 1'b0;
    m_ovf    = 1'b0;
    m_rdy_en = 1'b0;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst = 1'b0;
    #1;
    check_all("rst_release");
  endtask

  function automatic ent_t mk(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    ent_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    return e;
  endfunction

  initial begin
    int sent;
    #2;
    do_reset();
    idle("post_rst", 1, 1'b1);
    chk("post_rst_ready", 64'(tready_out), 64'd1);
    chk("post_rst_level", 64'(level), 64'd0);

    // Streaming 1..8 with TLAST on the 8th
    for (int i = 1; i <= 8; i++) cycle("stream", 1'b1, mk(DW'(i), '1, i == 8), 1'b1);
    idle("stream_drain", 4, 1'b1);

    // Backpressure: six offers, five held, sixth dropped
    do_reset();
    idle("bp_pre", 1, 1'b0);
    for (int i = 1; i <= 6; i++) cycle("bp", 1'b1, mk(DW'(i), '1, 1'b1), 1'b0);
    chk("bp_level", 64'(level), 64'd4);
    chk("bp_ready", 64'(tready_out), 64'd0);
    chk("bp_tdata", 64'(m_tdata), 64'd1);
    chk("bp_overflow", 64'(ovf), 64'd1);
    idle("bp_stall", 3, 1'b0);
    chk("bp_tdata_stable", 64'(m_tdata), 64'd1);
    idle("bp_drain", 7, 1'b1);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    do_reset();
    chk("ovf_cleared", 64'(ovf), 64'd0);
    idle("ovf_post", 1, 1'b1);

    // Wrap: 20 words, random downstream stalls, narrow TKEEP on the last
    sent = 0;
    for (int c = 0; c < 400 && sent < 20; c++) begin
      logic go;
      go = model_ready() && ($urandom_range(0, 3) != 0);
      cycle("wrap", go, mk(DW'(100 + sent), (sent == 19) ? KW'(4'h3) : '1, sent == 19),
            1'($urandom_range(0, 1)));
      if (go) sent++;
    end
    chk("wrap_sent", 64'(sent), 64'd20);
    idle("wrap_drain", 8, 1'b1);

    // Fully random traffic, then reset while data is in flight
    for (int c = 0; c < 300; c++) begin
      cycle("rand", 1'($urandom_range(0, 1)), mk(DW'($urandom), KW'($urandom),
            1'($urandom_range(0, 3) == 0)), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) cycle("mid_fill", 1'b1, mk(DW'(i + 50), '1, 1'b0), 1'b0);
    do_reset();
    idle("mid_post", 2, 1'b1);

`ifdef AXIS_MASTER_FIFO_PACKET_MODE_EN
    // Store-and-forward: nothing leaves until the TLAST word is stored
    cycle("pkt3", 1'b1, mk(DW'(32'hA1), '1, 1'b0), 1'b1);
    idle("pkt3_gap", 1, 1'b1);
    cycle("pkt3", 1'b1, mk(DW'(32'hA2), '1, 1'b0), 1'b1);
    idle("pkt3_gap", 1, 1'b1);
    chk("pkt3_hold", 64'(m_tvalid), 64'd0);
    cycle("pkt3", 1'b1, mk(DW'(32'hA3), '1, 1'b1), 1'b1);
    idle("pkt3_drain", 5, 1'b1);
    // Packet longer than the FIFO must drain via the full fallback
    sent = 0;
    for (int c = 0; c < 60 && sent < 6; c++) begin
      logic go;
      go = model_ready();
      cycle("pkt6", go, mk(DW'(32'hB0 + sent), '1, sent == 5), 1'b1);
      if (go) sent++;
    end
    chk("pkt6_sent", 64'(sent), 64'd6);
    idle("pkt6_drain", 8, 1'b1);
    chk("pkt6_empty", 64'(level), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
